// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO and stalls the
// upstream pipe registers while a MULT/MULTU/DIV/DIVU iterates one bit per cycle.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | accepting ops; MTHI/MTLO write here, mul/div latch operands
//  S_RUN  | one product/quotient bit per cycle, counter counts down
//  S_DONE | HI/LO valid, done pulse, instruction leaves ID/EX
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q;    // partial high product / running remainder
   logic [WIDTH-1:0] quo_q;    // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0] opnd_q;   // |multiplicand| or |divisor|
   logic             is_div_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic             dz_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic             is_mul_op, is_div_op, is_signed_op, is_long_op, b_zero;
   logic [WIDTH-1:0] a_abs, b_abs;

   assign is_mul_op    = (op_i == OP_MULT) || (op_i == OP_MULTU);
   assign is_div_op    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
   assign is_signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign is_long_op   = is_mul_op || is_div_op;
   assign b_zero       = (src_b_i == {WIDTH{1'b0}});
   assign a_abs        = (is_signed_op && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
   assign b_abs        = (is_signed_op && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

   logic [WIDTH:0]     add_sum, sub_shift, sub_diff;
   logic [WIDTH-1:0]   acc_nxt, quo_nxt;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      add_sum   = {1'b0, acc_q} + {1'b0, (quo_q[0] ? opnd_q : {WIDTH{1'b0}})};
      sub_shift = {acc_q, quo_q[WIDTH-1]};
      sub_diff  = sub_shift - {1'b0, opnd_q};
      if (is_div_q) begin
         // restoring step: keep the difference only when it did not borrow
         if (!sub_diff[WIDTH]) begin
            acc_nxt = sub_diff[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = sub_shift[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = add_sum[WIDTH:1];
         quo_nxt = {add_sum[0], quo_q[WIDTH-1:1]};
      end
      prod_fix = neg_q_q ? -{acc_nxt, quo_nxt} : {acc_nxt, quo_nxt};
      quo_fix  = neg_q_q ? -quo_nxt : quo_nxt;
      rem_fix  = neg_r_q ? -acc_nxt : acc_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      stall_o       = 1'b0;
      busy_o        = (state_q != S_IDLE);
      done_o        = 1'b0;
      div_by_zero_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && is_long_op) begin
               stall_o = 1'b1;
               state_d = (is_div_op && b_zero) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            stall_o = 1'b1;
            if (cnt_q == {CW{1'b0}}) state_d = S_DONE;
         end
         S_DONE: begin
            done_o        = 1'b1;
            div_by_zero_o = dz_q;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= {CW{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         quo_q    <= {WIDTH{1'b0}};
         opnd_q   <= {WIDTH{1'b0}};
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (op_i == OP_MTHI) begin
                     hi_q <= src_a_i;
                  end else if (op_i == OP_MTLO) begin
                     lo_q <= src_a_i;
                  end else if (is_div_op && b_zero) begin
                     hi_q <= src_a_i;
                     lo_q <= {WIDTH{1'b1}};
                     dz_q <= 1'b1;
                  end else if (is_long_op) begin
                     is_div_q <= is_div_op;
                     neg_q_q  <= is_signed_op && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                     neg_r_q  <= is_signed_op && is_div_op && src_a_i[WIDTH-1];
                     cnt_q    <= CW'(WIDTH - 1);
                     acc_q    <= {WIDTH{1'b0}};
                     quo_q    <= a_abs;
                     opnd_q   <= b_abs;
                  end
               end
            end
            S_RUN: begin
               acc_q <= acc_nxt;
               quo_q <= quo_nxt;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == {CW{1'b0}}) begin
                  if (is_div_q) begin
                     lo_q <= quo_fix;
                     hi_q <= rem_fix;
                  end else begin
                     {hi_q, lo_q} <= prod_fix;
                  end
               end
            end
            S_DONE: dz_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed cases plus random ops, compared every cycle
// against an arithmetic reference model of HI/LO and the stall/done timing.
module tb_ex_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          stall_o, busy_o, done_o, div_by_zero_o;
   logic [W-1:0]  hi_o, lo_o;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
      .src_a_i(a), .src_b_i(b),
      .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
      .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   int           m_run  = 0;
   bit           m_done = 0;
   bit           m_dz   = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void ref_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] rh, output logic [W-1:0] rl);
      longint sx, sy;
      logic [63:0] p;
      int ix, iy;
      rh = '0; rl = '0;
      case (o)
         3'd1: begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p = 64'(sx * sy);
            rh = p[63:32]; rl = p[31:0];
         end
         3'd2: begin
            p = {32'b0, x} * {32'b0, y};
            rh = p[63:32]; rl = p[31:0];
         end
         3'd3: begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               rl = 32'h8000_0000; rh = '0;
            end else begin
               ix = $signed(x); iy = $signed(y);
               rl = 32'(ix / iy); rh = 32'(ix % iy);
            end
         end
         3'd4: begin
            rl = x / y; rh = x % y;
         end
         default: ;
      endcase
   endfunction

   // reference model: advanced on each rising edge from the inputs held during the cycle
   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
      end else if (m_done) begin
         m_done = 0; m_dz = 0;
      end else if (m_run > 0) begin
         m_run--;
         if (m_run == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1;
         end
      end else if (start) begin
         case (op)
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            3'd1, 3'd2, 3'd3, 3'd4: begin
               if ((op == 3'd3 || op == 3'd4) && b == '0) begin
                  m_hi = a; m_lo = '1; m_done = 1; m_dz = 1;
               end else begin
                  ref_result(op, a, b, p_hi, p_lo);
                  m_run = W;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", W'(stall_o),
             W'((m_run > 0) || (!m_done && start && (op inside {[3'd1:3'd4]}))));
         chk("busy", W'(busy_o), W'((m_run > 0) || m_done));
         chk("done", W'(done_o), W'(m_done));
         chk("div_by_zero", W'(div_by_zero_o), W'(m_done && m_dz));
         chk("hi", hi_o, m_hi);
         chk("lo", lo_o, m_lo);
      end
   end

   // called at posedge+1; returns at posedge+1 of the cycle after the op finished
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int stalls, output int dones, output int dzs);
      bit long_op, finished;
      long_op = (o inside {[3'd1:3'd4]});
      finished = 0;
      op = o; a = x; b = y; start = 1'b1;
      stalls = 0; dones = 0; dzs = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (done_o) dones++;
         if (div_by_zero_o) dzs++;
         if (done_o || !long_op) begin
            finished = 1;
            break;
         end
      end
      if (!finished) begin
         n_cmp++; n_err++;
         $display("FAIL timeout: op %0d got no done_o within 80 cycles", o);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int s, d, z, exp_s;
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_hi", hi_o, 32'h0);
      chk("reset_lo", lo_o, 32'h0);
      chk("reset_stall", W'(stall_o), 32'h0);
      @(posedge clk); #1;

      run_op(3'd5, 32'h1234, 32'h0, s, d, z);
      chk("mthi_stall", W'(s), 32'd0);
      run_op(3'd6, 32'h5678, 32'h0, s, d, z);
      chk("mtlo_stall", W'(s), 32'd0);
      chk("mt_hi", hi_o, 32'h1234);
      chk("mt_lo", lo_o, 32'h5678);

      run_op(3'd1, 32'd7, 32'hFFFF_FFFD, s, d, z);
      chk("mult_stall_len", W'(s), 32'd33);
      chk("mult_hi", hi_o, 32'hFFFF_FFFF);
      chk("mult_lo", lo_o, 32'hFFFF_FFEB);

      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, d, z);
      chk("multu_done_cnt", W'(d), 32'd1);
      chk("multu_hi", hi_o, 32'hFFFF_FFFE);
      chk("multu_lo", lo_o, 32'h0000_0001);

      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, s, d, z);
      chk("div_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_hi", hi_o, 32'hFFFF_FFFF);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, s, d, z);
      chk("divovf_lo", lo_o, 32'h8000_0000);
      chk("divovf_hi", hi_o, 32'h0);

      run_op(3'd4, 32'd100, 32'd0, s, d, z);
      chk("dz_stall_len", W'(s), 32'd1);
      chk("dz_flag", W'(z), 32'd1);
      chk("dz_hi", hi_o, 32'h0000_0064);
      chk("dz_lo", lo_o, 32'hFFFF_FFFF);

      // reset in the middle of a multiply
      op = 3'd1; a = 32'd5; b = 32'd5; start = 1'b1;
      @(negedge clk);
      repeat (9) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstrun_stall", W'(stall_o), 32'h0);
      chk("rstrun_busy", W'(busy_o), 32'h0);
      chk("rstrun_hi", hi_o, 32'h0);
      chk("rstrun_lo", lo_o, 32'h0);
      @(posedge clk); #1;

      run_op(3'd4, 32'd1000, 32'd7, s, d, z);
      run_op(3'd2, 32'd3, 32'd4, s, d, z);
      chk("b2b_multu_lo", lo_o, 32'h0000_000C);
      chk("b2b_multu_hi", hi_o, 32'h0);

      for (int k = 0; k < 60; k++) begin
         ro = 3'($urandom_range(0, 7));
         ra = rnd_val();
         rb = rnd_val();
         run_op(ro, ra, rb, s, d, z);
         if ((ro == 3'd3 || ro == 3'd4) && rb == '0) exp_s = 1;
         else if (ro inside {[3'd1:3'd4]})          exp_s = 33;
         else                                        exp_s = 0;
         chk("rand_stall_len", W'(s), W'(exp_s));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
